// File: rtl/uart_transmitter_pkg.sv
// Shared UART transmit definitions: FSM encodings, frame constants, parity mode
// and the baud-code to tick-divisor table for the 50 MHz system clock.
package uart_transmitter_pkg;

    localparam int unsigned CLK_HZ          = 50_000_000;
    localparam int unsigned OVERSAMPLE_RATE = 16;
    localparam int unsigned FRAME_BITS      = 11;
    localparam int unsigned BAUD_CNT_W      = 14;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_WAIT   = 4'd1,
        ST_START  = 4'd2,
        ST_DATA   = 4'd3,
        ST_PARITY = 4'd4,
        ST_STOP   = 4'd5
    } tx_state_t;

    typedef enum logic {
        PARITY_EVEN = 1'b0,
        PARITY_ODD  = 1'b1
    } parity_mode_t;

    localparam parity_mode_t PARITY_MODE = PARITY_EVEN;

    // Clocks per oversample tick: round(CLK_HZ / (16 * baud)).
    function automatic logic [BAUD_CNT_W-1:0] baud_divisor(input logic [2:0] sel);
        logic [BAUD_CNT_W-1:0] div;
        div = 14'd27;
        case (sel)
            3'd0:    div = 14'd10417;  // 300
            3'd1:    div = 14'd2604;   // 1200
            3'd2:    div = 14'd651;    // 4800
            3'd3:    div = 14'd326;    // 9600
            3'd4:    div = 14'd163;    // 19200
            3'd5:    div = 14'd81;     // 38400
            3'd6:    div = 14'd54;     // 57600
            default: div = 14'd27;     // 115200
        endcase
        return div;
    endfunction

    function automatic logic calc_parity(input logic [7:0] data, input parity_mode_t mode);
        return (mode == PARITY_ODD) ? ~(^data) : (^data);
    endfunction

endpackage

// File: rtl/uart_transmitter_baud_controller.sv
// Free-running oversample tick generator: one-cycle sample_ENABLE pulse every
// baud_divisor(baud_select) clocks.
module baud_controller
    import uart_transmitter_pkg::*;
(
    input  logic       reset,
    input  logic       clk,
    input  logic [2:0] baud_select,
    output logic       sample_ENABLE
);

    logic [BAUD_CNT_W-1:0] count;
    logic [BAUD_CNT_W-1:0] last;

    assign last = baud_divisor(baud_select) - 14'd1;

    // >= rather than == so a lowered divisor can never strand the counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count         <= '0;
            sample_ENABLE <= 1'b0;
        end else if (count >= last) begin
            count         <= '0;
            sample_ENABLE <= 1'b1;
        end else begin
            count         <= count + 14'd1;
            sample_ENABLE <= 1'b0;
        end
    end

endmodule

// File: rtl/uart_transmitter.sv
// UART transmitter: start, 8 data bits LSB first, even parity, stop; each bit
// held for OVERSAMPLE baud ticks. TxD, Tx_BUSY and Tx_DONE are registered.
module uart_transmitter
    import uart_transmitter_pkg::*;
#(
    parameter int unsigned OVERSAMPLE = OVERSAMPLE_RATE,
    parameter int unsigned DATA_BITS  = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] baud_select,
    input  logic       Tx_EN,
    input  logic       Tx_WR,
    input  logic [7:0] Tx_DATA,
    output logic       TxD,
    output logic       Tx_BUSY,
    output logic       Tx_DONE
);

    localparam int unsigned TW = $clog2(OVERSAMPLE);
    localparam int unsigned BW = $clog2(DATA_BITS);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

    logic            Tx_sample_ENABLE;
    tx_state_t       state;
    logic [TW-1:0]   tick_cnt;
    logic [BW-1:0]   bit_cnt;
    logic [7:0]      shift;
    logic            parity;

    baud_controller baud_controller_tx_instance (
        .reset         (reset),
        .clk           (clk),
        .baud_select   (baud_select),
        .sample_ENABLE (Tx_sample_ENABLE)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            TxD      <= 1'b1;
            Tx_BUSY  <= 1'b0;
            Tx_DONE  <= 1'b0;
            tick_cnt <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
            parity   <= 1'b0;
        end else begin
            Tx_DONE <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (Tx_EN && Tx_WR) begin
                        shift   <= Tx_DATA;
                        parity  <= calc_parity(Tx_DATA, PARITY_MODE);
                        Tx_BUSY <= 1'b1;
                        state   <= ST_WAIT;
                    end
                end
                // Align the start bit to a tick boundary so every bit spans whole ticks.
                ST_WAIT: begin
                    if (Tx_sample_ENABLE) begin
                        state    <= ST_START;
                        TxD      <= 1'b0;
                        tick_cnt <= '0;
                    end
                end
                ST_START, ST_DATA, ST_PARITY, ST_STOP: begin
                    if (Tx_sample_ENABLE) begin
                        if (tick_cnt != TICK_LAST) begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end else begin
                            tick_cnt <= '0;
                            case (state)
                                ST_START: begin
                                    state   <= ST_DATA;
                                    bit_cnt <= '0;
                                    TxD     <= shift[0];
                                end
                                ST_DATA: begin
                                    shift <= shift >> 1;
                                    if (bit_cnt == BIT_LAST) begin
                                        state <= ST_PARITY;
                                        TxD   <= parity;
                                    end else begin
                                        bit_cnt <= bit_cnt + 1'b1;
                                        TxD     <= shift[1];
                                    end
                                end
                                ST_PARITY: begin
                                    state <= ST_STOP;
                                    TxD   <= 1'b1;
                                end
                                default: begin
                                    state   <= ST_IDLE;
                                    TxD     <= 1'b1;
                                    Tx_BUSY <= 1'b0;
                                    Tx_DONE <= 1'b1;
                                end
                            endcase
                        end
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    TxD     <= 1'b1;
                    Tx_BUSY <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_transmitter.sv
// Directed bench for uart_transmitter at baud_select=7 (27 clocks/tick, 432 clocks/bit);
// the line is sampled on every falling clock edge against hand-built frames.
module tb_uart_transmitter;

    localparam int BIT_CLKS   = 432;
    localparam int FRAME_CLKS = 11 * BIT_CLKS;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] baud_select;
    logic       Tx_EN;
    logic       Tx_WR;
    logic [7:0] Tx_DATA;
    logic       TxD;
    logic       Tx_BUSY;
    logic       Tx_DONE;

    int errors = 0;
    int checks = 0;

    uart_transmitter dut (
        .clk         (clk),
        .reset       (reset),
        .baud_select (baud_select),
        .Tx_EN       (Tx_EN),
        .Tx_WR       (Tx_WR),
        .Tx_DATA     (Tx_DATA),
        .TxD         (TxD),
        .Tx_BUSY     (Tx_BUSY),
        .Tx_DONE     (Tx_DONE)
    );

    always #5 clk = ~clk;

    // Optionally writes data, then follows one frame bit by bit. inj_at injects a
    // write mid-frame, abort_at asserts reset at that sample, chain writes chain_data
    // in the cycle Tx_DONE is seen. gap returns idle-high samples before the start bit.
    task automatic run_frame(input logic [7:0] data, input bit do_write,
                             input int inj_at, input logic [7:0] inj_data,
                             input int abort_at, input bit chain,
                             input logic [7:0] chain_data, output int gap);
        logic [10:0] frame;
        logic        bad_bit, bad_val, bad_busy, bad_done, found;
        frame = {1'b1, ^data, data, 1'b0};
        gap = 0;
        bad_busy = 1'b0;
        bad_done = 1'b0;
        bad_bit = 1'b0;
        bad_val = 1'b0;
        if (do_write) begin
            @(negedge clk);
            Tx_DATA = data;
            Tx_WR = 1'b1;
            @(negedge clk);
            Tx_WR = 1'b0;
            checks++;
            if (Tx_BUSY !== 1'b1) begin
                errors++;
                $display("FAIL accept_busy data=%02h: Tx_BUSY=%b expected 1", data, Tx_BUSY);
            end
        end
        found = 1'b0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (TxD === 1'b0) begin
                found = 1'b1;
                break;
            end
            gap++;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL start_timeout data=%02h: TxD=%b expected 0 within 64 cycles", data, TxD);
            return;
        end
        for (int n = 0; n < FRAME_CLKS; n++) begin
            if (n > 0) @(negedge clk);
            if (n == abort_at) begin
                reset = 1'b1;
                #1;
                checks++;
                if (TxD !== 1'b1 || Tx_BUSY !== 1'b0 || Tx_DONE !== 1'b0) begin
                    errors++;
                    $display("FAIL abort_reset: TxD=%b Tx_BUSY=%b Tx_DONE=%b expected 1 0 0",
                             TxD, Tx_BUSY, Tx_DONE);
                end
                @(negedge clk);
                reset = 1'b0;
                return;
            end
            if (n == inj_at) begin
                Tx_DATA = inj_data;
                Tx_WR = 1'b1;
            end
            if (n == inj_at + 1) begin
                Tx_WR = 1'b0;
                Tx_DATA = data;
            end
            if (TxD !== frame[n / BIT_CLKS]) begin
                bad_bit = 1'b1;
                bad_val = TxD;
            end
            if (Tx_BUSY !== 1'b1) bad_busy = 1'b1;
            if (Tx_DONE !== 1'b0) bad_done = 1'b1;
            if (n % BIT_CLKS == BIT_CLKS - 1) begin
                checks++;
                if (bad_bit) begin
                    errors++;
                    $display("FAIL frame_bit%0d data=%02h: TxD=%b expected %b",
                             n / BIT_CLKS, data, bad_val, frame[n / BIT_CLKS]);
                end
                bad_bit = 1'b0;
            end
        end
        checks++;
        if (bad_busy) begin
            errors++;
            $display("FAIL busy_in_frame data=%02h: Tx_BUSY=0 expected 1", data);
        end
        checks++;
        if (bad_done) begin
            errors++;
            $display("FAIL done_early data=%02h: Tx_DONE=1 expected 0", data);
        end
        @(negedge clk);
        checks++;
        if (Tx_DONE !== 1'b1 || Tx_BUSY !== 1'b0 || TxD !== 1'b1) begin
            errors++;
            $display("FAIL frame_end data=%02h: Tx_DONE=%b Tx_BUSY=%b TxD=%b expected 1 0 1",
                     data, Tx_DONE, Tx_BUSY, TxD);
        end
        if (chain) begin
            Tx_DATA = chain_data;
            Tx_WR = 1'b1;
        end
        @(negedge clk);
        Tx_WR = 1'b0;
        checks++;
        if (Tx_DONE !== 1'b0) begin
            errors++;
            $display("FAIL done_pulse_width data=%02h: Tx_DONE=%b expected 0", data, Tx_DONE);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        baud_select = 3'd7;
        Tx_EN = 1'b0;
        Tx_WR = 1'b0;
        Tx_DATA = 8'h00;
        repeat (3) @(negedge clk);
        checks++;
        if (TxD !== 1'b1) begin
            errors++;
            $display("FAIL reset_txd: TxD=%b expected 1", TxD);
        end
        checks++;
        if (Tx_BUSY !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy: Tx_BUSY=%b expected 0", Tx_BUSY);
        end
        checks++;
        if (Tx_DONE !== 1'b0) begin
            errors++;
            $display("FAIL reset_done: Tx_DONE=%b expected 0", Tx_DONE);
        end
        reset = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_frame_a5();
        int gap;
        Tx_EN = 1'b1;
        run_frame(8'hA5, 1'b1, -1, 8'h00, -1, 1'b0, 8'h00, gap);
        repeat (50) @(negedge clk);
    endtask

    task automatic test_parity_07();
        int gap;
        run_frame(8'h07, 1'b1, -1, 8'h00, -1, 1'b0, 8'h00, gap);
        repeat (50) @(negedge clk);
    endtask

    task automatic test_ignored_writes();
        int  gap;
        logic bad;
        Tx_EN = 1'b0;
        @(negedge clk);
        Tx_DATA = 8'h3C;
        Tx_WR = 1'b1;
        @(negedge clk);
        Tx_WR = 1'b0;
        bad = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (TxD !== 1'b1 || Tx_BUSY !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL en_low_write: TxD/Tx_BUSY moved, final TxD=%b Tx_BUSY=%b expected 1 0",
                     TxD, Tx_BUSY);
        end
        Tx_EN = 1'b1;
        run_frame(8'h55, 1'b1, 2000, 8'h3C, -1, 1'b0, 8'h00, gap);
        bad = 1'b0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (TxD !== 1'b1 || Tx_BUSY !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL dropped_write: line active after frame, TxD=%b Tx_BUSY=%b expected 1 0",
                     TxD, Tx_BUSY);
        end
    endtask

    task automatic test_reset_mid_frame();
        int gap;
        run_frame(8'hFF, 1'b1, -1, 8'h00, 4 * BIT_CLKS + 200, 1'b0, 8'h00, gap);
        repeat (20) @(negedge clk);
        run_frame(8'h12, 1'b1, -1, 8'h00, -1, 1'b0, 8'h00, gap);
        repeat (50) @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int gap;
        run_frame(8'hFF, 1'b1, -1, 8'h00, -1, 1'b1, 8'h00, gap);
        run_frame(8'h00, 1'b0, -1, 8'h00, -1, 1'b0, 8'h00, gap);
        checks++;
        if (gap + 2 > 27) begin
            errors++;
            $display("FAIL b2b_gap: idle samples=%0d expected <= 27", gap + 2);
        end
    endtask

    initial begin
        test_reset();
        test_frame_a5();
        test_parity_07();
        test_ignored_writes();
        test_reset_mid_frame();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
